// File: rtl/wb_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the Wishbone RAM arbiter slice.
//   arb_state_t       : arbiter FSM states
//   MAX_OUTSTANDING   : pipelined transfers allowed in flight per grant
//   OUTSTANDING_WIDTH : counter width able to hold MAX_OUTSTANDING itself
// ---------------------------------------------------------------------------
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } arb_state_t;

  localparam int MAX_OUTSTANDING   = 4;
  localparam int OUTSTANDING_WIDTH = $clog2(MAX_OUTSTANDING) + 1;

endpackage

// File: rtl/wb_watchdog.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wb_watchdog
// Tracks pipelined transfers still waiting for an ack and times out a
// target that stops answering.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   accept     : a strobe was taken by the target this cycle
//   ack        : the target acknowledged a transfer this cycle
//   clear      : drop all tracking state (no grant active)
//   full       : MAX_OUTSTANDING transfers are in flight
//   expired    : the ack wait reached TIMEOUT_CYCLES - 1
// ---------------------------------------------------------------------------
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic ack,
  input  logic clear,
  output logic full,
  output logic expired
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0] WD_TERMINAL = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [OUTSTANDING_WIDTH-1:0] OUT_MAX = OUTSTANDING_WIDTH'(MAX_OUTSTANDING);

  logic [OUTSTANDING_WIDTH-1:0] outstanding;
  logic [WD_WIDTH-1:0]          wd_count;
  logic                         inc;
  logic                         dec;

  // Guards keep the counter from wrapping in either direction.
  assign inc = accept && (outstanding != OUT_MAX);
  assign dec = ack && (outstanding != '0);

  assign full    = (outstanding == OUT_MAX);
  assign expired = (wd_count == WD_TERMINAL);

  // Outstanding transfers: an accept and an ack in the same cycle cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (clear) begin
      outstanding <= '0;
    end else if (inc && !dec) begin
      outstanding <= outstanding + 1'b1;
    end else if (dec && !inc) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // Ack wait timer: runs only while something is in flight and no ack
  // shows up, and holds at the terminal count until the FSM reacts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_count <= '0;
    end else if (clear || ack || (outstanding == '0)) begin
      wd_count <= '0;
    end else if (wd_count != WD_TERMINAL) begin
      wd_count <= wd_count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wb_ram_arbiter
// Two-initiator Wishbone B4 pipelined arbiter in front of the SRAM
// controller. Initiator 0 is the SPI host bridge, initiator 1 the CPU/video
// bus. One initiator owns the target for a whole bus cycle; contention is
// resolved round-robin and a stuck target is aborted by a watchdog.
// Ports:
//   wb_clock_i, wb_reset_n_i        : clock, asynchronous active-low reset
//   mN_addr_i/data_i/we_i           : initiator N request fields
//   mN_cycle_i/strobe_i             : initiator N bus cycle and strobe
//   mN_data_o                       : read data (fan-out of s_data_i)
//   mN_stall_o/ack_o/err_o          : initiator N responses
//   s_addr_o/data_o/we_o            : request fields to the RAM target
//   s_cycle_o/strobe_o              : cycle and strobe to the RAM target
//   s_data_i/stall_i/ack_i          : responses from the RAM target
// ---------------------------------------------------------------------------
module wb_ram_arbiter
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_n_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  input  logic                  m0_we_i,
  input  logic                  m0_cycle_i,
  input  logic                  m0_strobe_i,
  output logic                  m0_stall_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  input  logic                  m1_we_i,
  input  logic                  m1_cycle_i,
  input  logic                  m1_strobe_i,
  output logic                  m1_stall_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic                  s_we_o,
  output logic                  s_cycle_o,
  output logic                  s_strobe_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_stall_i,
  input  logic                  s_ack_i
);

  arb_state_t state;
  arb_state_t next_state;
  logic       last_grant;
  logic       next_last_grant;

  logic                  req0;
  logic                  req1;
  logic                  granted;
  logic                  sel1;
  logic                  sel_cycle;
  logic                  sel_strobe;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  full;
  logic                  expired;
  logic                  accept;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  assign req0    = m0_cycle_i & m0_strobe_i;
  assign req1    = m1_cycle_i & m1_strobe_i;
  assign granted = (state == GRANT0) || (state == GRANT1);
  assign sel1    = (state == GRANT1);

  assign sel_cycle  = sel1 ? m1_cycle_i  : m0_cycle_i;
  assign sel_strobe = sel1 ? m1_strobe_i : m0_strobe_i;
  assign sel_we     = sel1 ? m1_we_i     : m0_we_i;
  assign sel_addr   = sel1 ? m1_addr_i   : m0_addr_i;
  assign sel_data   = sel1 ? m1_data_i   : m0_data_i;

  assign accept = s_strobe_o & ~s_stall_i;

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (wb_clock_i),
    .rst_n  (wb_reset_n_i),
    .accept (accept),
    .ack    (s_ack_i & granted),
    .clear  (~granted),
    .full   (full),
    .expired(expired)
  );

  // State register. last_grant starts at 1 so initiator 0 wins the very
  // first contention.
  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  // Next state and all bus outputs. Outputs depend only on the state
  // register and live inputs, so an asynchronous reset drops cycle and
  // strobe together without a clock edge.
  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    s_cycle_o       = 1'b0;
    s_strobe_o      = 1'b0;
    s_we_o          = 1'b0;
    s_addr_o        = '0;
    s_data_o        = '0;
    m0_stall_o      = 1'b1;
    m1_stall_o      = 1'b1;
    m0_ack_o        = 1'b0;
    m1_ack_o        = 1'b0;
    m0_err_o        = 1'b0;
    m1_err_o        = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_grant)) begin
          next_state = GRANT0;
        end else if (req1) begin
          next_state = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        // Strobe is held back while full so the target never takes a
        // transfer the initiator sees as stalled.
        s_cycle_o  = sel_cycle;
        s_strobe_o = sel_cycle & sel_strobe & ~full;
        s_we_o     = sel_we;
        s_addr_o   = sel_addr;
        s_data_o   = sel_data;
        if (sel1) begin
          m1_stall_o = s_stall_i | full;
          m1_ack_o   = s_ack_i & sel_cycle;
        end else begin
          m0_stall_o = s_stall_i | full;
          m0_ack_o   = s_ack_i & sel_cycle;
        end
        // Recording the owner on entry to ABORT lets ABORT route err
        // through last_grant; arbitration only reads it in IDLE.
        if (!sel_cycle) begin
          next_state      = IDLE;
          next_last_grant = sel1;
        end else if (expired && !s_ack_i) begin
          next_state      = ABORT;
          next_last_grant = sel1;
        end
      end
      ABORT: begin
        if (last_grant) begin
          m1_err_o = 1'b1;
        end else begin
          m0_err_o = 1'b1;
        end
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_wb_ram_arbiter
// Directed bench for wb_ram_arbiter with a small RAM target model that
// acks each accepted strobe a fixed four edges later.
// ---------------------------------------------------------------------------
module tb_wb_ram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int TO = 32;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_we = 1'b0, m0_cyc = 1'b0, m0_stb = 1'b0;
  logic          m1_we = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_stall, m0_ack, m0_err;
  logic          m1_stall, m1_ack, m1_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_dout;
  logic          s_we, s_cyc, s_stb;
  logic [DW-1:0] s_din;
  logic          s_ack;

  logic          ram_stall  = 1'b0;
  logic          ack_enable = 1'b1;
  logic          ovr_en     = 1'b0;
  logic [DW-1:0] ovr_data   = '0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clock_i(clk),          .wb_reset_n_i(rst_n),
    .m0_addr_i(m0_addr),       .m0_data_i(m0_wdata),     .m0_data_o(m0_rdata),
    .m0_we_i(m0_we),           .m0_cycle_i(m0_cyc),      .m0_strobe_i(m0_stb),
    .m0_stall_o(m0_stall),     .m0_ack_o(m0_ack),        .m0_err_o(m0_err),
    .m1_addr_i(m1_addr),       .m1_data_i(m1_wdata),     .m1_data_o(m1_rdata),
    .m1_we_i(m1_we),           .m1_cycle_i(m1_cyc),      .m1_strobe_i(m1_stb),
    .m1_stall_o(m1_stall),     .m1_ack_o(m1_ack),        .m1_err_o(m1_err),
    .s_addr_o(s_addr),         .s_data_o(s_dout),        .s_we_o(s_we),
    .s_cycle_o(s_cyc),         .s_strobe_o(s_stb),
    .s_data_i(s_din),          .s_stall_i(ram_stall),    .s_ack_i(s_ack)
  );

  // RAM target model: preloads 0x100..0x103 with 0x10..0x13 while reset is
  // low, and returns an ack plus read data four edges after acceptance.
  // The pipeline is deliberately not reset so stale acks can be produced.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [3:0]    pipe_valid = '0;
  logic [DW-1:0] pipe_data [4] = '{default: '0};
  logic          model_accept;

  assign model_accept = s_cyc & s_stb & ~ram_stall & ack_enable;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[AW'(17'h00100 + i)] <= 8'(8'h10 + i);
    end else if (model_accept && s_we) begin
      mem[s_addr] <= s_dout;
    end
    pipe_valid   <= {pipe_valid[2:0], model_accept};
    pipe_data[0] <= mem[s_addr];
    for (int i = 1; i < 4; i++) pipe_data[i] <= pipe_data[i-1];
  end

  assign s_ack = pipe_valid[3];
  assign s_din = ovr_en ? ovr_data : pipe_data[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack0(output bit got, output logic [DW-1:0] rd);
    got = 1'b0;
    rd  = '0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (m0_ack) begin got = 1'b1; rd = m0_rdata; end
    end
  endtask

  task automatic wait_ack1(output bit got, output logic [DW-1:0] rd);
    got = 1'b0;
    rd  = '0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (m1_ack) begin got = 1'b1; rd = m1_rdata; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ovr_en = 1'b1; ovr_data = 8'h3C;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    repeat (3) tick();
    compared++; if (s_cyc !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s_cycle: got %b want 0", s_cyc); end
    compared++; if (s_stb !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s_strobe: got %b want 0", s_stb); end
    compared++; if (s_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s_we: got %b want 0", s_we); end
    compared++; if (s_addr !== 17'h0) begin mismatched++; $display("[TB] FAIL reset_s_addr: got %h want 0", s_addr); end
    compared++; if (s_dout !== 8'h0) begin mismatched++; $display("[TB] FAIL reset_s_data: got %h want 0", s_dout); end
    compared++; if (m0_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_m0_stall: got %b want 1", m0_stall); end
    compared++; if (m1_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_m1_stall: got %b want 1", m1_stall); end
    compared++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_ack_err: got %b want 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    compared++; if (m0_rdata !== 8'h3C) begin mismatched++; $display("[TB] FAIL reset_m0_data: got %h want 3c", m0_rdata); end
    compared++; if (m1_rdata !== 8'h3C) begin mismatched++; $display("[TB] FAIL reset_m1_data: got %h want 3c", m1_rdata); end
    m0_cyc = 1'b0; m0_stb = 1'b0; ovr_en = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    bit got;
    logic [DW-1:0] rd;
    m0_addr = 17'h00100; m0_we = 1'b0; m1_addr = 17'h00101; m1_we = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    compared++; if ({m0_stall, m1_stall} !== 2'b11) begin mismatched++; $display("[TB] FAIL cont_request_cycle_stall: got %b want 11", {m0_stall, m1_stall}); end
    tick();
    compared++; if ({m0_stall, m1_stall, s_stb} !== 3'b011) begin mismatched++; $display("[TB] FAIL cont_first_grant_m0: got m0s/m1s/stb=%b want 011", {m0_stall, m1_stall, s_stb}); end
    compared++; if (s_addr !== 17'h00100) begin mismatched++; $display("[TB] FAIL cont_first_addr: got %h want 00100", s_addr); end
    tick();
    m0_stb = 1'b0;
    wait_ack0(got, rd);
    compared++; if (got !== 1'b1 || rd !== 8'h10) begin mismatched++; $display("[TB] FAIL cont_m0_read: got ack=%b data=%h want 1/10", got, rd); end
    tick();
    m0_cyc = 1'b0;
    #1;
    compared++; if (m1_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL cont_release_cycle: got m1_stall=%b want 1", m1_stall); end
    tick();
    compared++; if ({s_cyc, m1_stall} !== 2'b01) begin mismatched++; $display("[TB] FAIL cont_idle_gap: got cyc/m1_stall=%b want 01", {s_cyc, m1_stall}); end
    tick();
    compared++; if (m1_stall !== 1'b0 || s_addr !== 17'h00101) begin mismatched++; $display("[TB] FAIL cont_m1_granted: got stall=%b addr=%h want 0/00101", m1_stall, s_addr); end
    m0_addr = 17'h00102; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    compared++; if (m0_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL cont_m0_waits: got %b want 1", m0_stall); end
    tick();
    m1_stb = 1'b0;
    wait_ack1(got, rd);
    compared++; if (got !== 1'b1 || rd !== 8'h11) begin mismatched++; $display("[TB] FAIL cont_m1_read: got ack=%b data=%h want 1/11", got, rd); end
    tick();
    m1_cyc = 1'b0;
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    compared++; if ({m0_stall, m1_stall} !== 2'b01 || s_addr !== 17'h00102) begin mismatched++; $display("[TB] FAIL cont_round_robin: got m0s/m1s=%b addr=%h want 01/00102", {m0_stall, m1_stall}, s_addr); end
    tick();
    m0_stb = 1'b0;
    wait_ack0(got, rd);
    tick();
    m0_cyc = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single_write_read();
    bit got;
    logic [DW-1:0] rd;
    int acks = 0;
    int m1_bad = 0;
    m0_addr = 17'h10000; m0_wdata = 8'hA5; m0_we = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    compared++; if ({s_stb, m0_stall} !== 2'b01) begin mismatched++; $display("[TB] FAIL single_latency: got stb/stall=%b want 01", {s_stb, m0_stall}); end
    tick();
    compared++; if ({s_stb, s_we, m1_stall} !== 3'b111 || s_addr !== 17'h10000 || s_dout !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_write_fwd: got stb/we/m1s=%b addr=%h data=%h want 111/10000/a5", {s_stb, s_we, m1_stall}, s_addr, s_dout); end
    tick();
    m0_stb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m0_ack) acks++;
      if (m1_stall !== 1'b1 || m1_ack !== 1'b0) m1_bad++;
    end
    compared++; if (acks !== 1) begin mismatched++; $display("[TB] FAIL single_write_ack_count: got %0d want 1", acks); end
    compared++; if (m1_bad !== 0) begin mismatched++; $display("[TB] FAIL single_m1_blocked: got %0d bad cycles want 0", m1_bad); end
    m0_cyc = 1'b0; m0_we = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    tick();
    m0_stb = 1'b0;
    wait_ack0(got, rd);
    compared++; if (got !== 1'b1 || rd !== 8'hA5) begin mismatched++; $display("[TB] FAIL single_readback: got ack=%b data=%h want 1/a5", got, rd); end
    tick();
    m0_cyc = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_pipelined();
    int issued = 0;
    int acks = 0;
    int extra = 0;
    int errs = 0;
    bit take;
    bit checked_full = 1'b0;
    logic full_stall = 1'b0;
    logic [DW-1:0] rd [4] = '{default: '0};
    m1_addr = 17'h00100; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int n = 0; n < 30 && acks < 4; n++) begin
      #1;
      if (m1_ack) begin
        if (acks < 4) rd[acks] = m1_rdata;
        acks++;
      end
      if (issued == 4 && !checked_full) begin full_stall = m1_stall; checked_full = 1'b1; end
      take = m1_stb && !m1_stall;
      tick();
      if (take) begin
        issued++;
        if (issued == 4) m1_stb = 1'b0;
        else m1_addr = m1_addr + 1'b1;
      end
    end
    compared++; if (issued !== 4 || acks !== 4) begin mismatched++; $display("[TB] FAIL pipe_counts: got issued=%0d acks=%0d want 4/4", issued, acks); end
    compared++; if (full_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL pipe_full_stall: got %b want 1", full_stall); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (rd[i] !== 8'(8'h10 + i)) begin mismatched++; $display("[TB] FAIL pipe_order_%0d: got %h want %h", i, rd[i], 8'(8'h10 + i)); end
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m1_err) errs++;
      if (m1_ack) extra++;
    end
    compared++; if (errs !== 0 || extra !== 0) begin mismatched++; $display("[TB] FAIL pipe_drained: got errs=%0d extra_acks=%0d want 0/0", errs, extra); end
    m1_cyc = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    bit got;
    logic [DW-1:0] rd;
    int first = -1;
    int err_cnt = 0;
    logic cyc_at_err = 1'b1;
    logic [1:0] after_err = 2'b00;
    ack_enable = 1'b0;
    m0_addr = 17'h00200; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    compared++; if (s_stb !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_granted: got %b want 1", s_stb); end
    tick();
    m0_stb = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (m0_err) begin
        err_cnt++;
        if (first < 0) begin first = i; cyc_at_err = s_cyc; end
      end
      if (first >= 0 && i == first + 1) after_err = {s_cyc, m0_stall};
      tick();
    end
    compared++; if (first !== 32 || err_cnt !== 1) begin mismatched++; $display("[TB] FAIL timeout_err_pulse: got first=%0d count=%0d want 32/1", first, err_cnt); end
    compared++; if (cyc_at_err !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_cycle_drop: got %b want 0", cyc_at_err); end
    compared++; if (after_err !== 2'b01) begin mismatched++; $display("[TB] FAIL timeout_idle: got cyc/stall=%b want 01", after_err); end
    ack_enable = 1'b1;
    m0_stb = 1'b1;
    tick();
    compared++; if ({s_stb, m0_stall} !== 2'b10) begin mismatched++; $display("[TB] FAIL timeout_regrant: got stb/stall=%b want 10", {s_stb, m0_stall}); end
    tick();
    m0_stb = 1'b0;
    wait_ack0(got, rd);
    tick();
    m0_cyc = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_cycle();
    bit got;
    logic [DW-1:0] rd;
    int stale = 0;
    m1_addr = 17'h00102; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    tick();
    m1_addr = 17'h00103;
    #2;
    compared++; if ({s_cyc, s_stb} !== 2'b11) begin mismatched++; $display("[TB] FAIL midrst_before: got cyc/stb=%b want 11", {s_cyc, s_stb}); end
    rst_n = 1'b0;
    #1;
    compared++; if ({s_cyc, s_stb, m1_stall} !== 3'b001) begin mismatched++; $display("[TB] FAIL midrst_async_drop: got cyc/stb/stall=%b want 001", {s_cyc, s_stb, m1_stall}); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (m1_ack) stale++; end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); if (m1_ack) stale++; end
    compared++; if (stale !== 0) begin mismatched++; $display("[TB] FAIL midrst_stale_ack: got %0d acks want 0", stale); end
    m1_addr = 17'h00102; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    compared++; if (m1_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_fresh_wait: got %b want 1", m1_stall); end
    tick();
    compared++; if ({s_stb, m1_stall} !== 2'b10 || s_addr !== 17'h00102) begin mismatched++; $display("[TB] FAIL midrst_fresh_grant: got stb/stall=%b addr=%h want 10/00102", {s_stb, m1_stall}, s_addr); end
    tick();
    m1_stb = 1'b0;
    wait_ack1(got, rd);
    compared++; if (got !== 1'b1 || rd !== 8'h12) begin mismatched++; $display("[TB] FAIL midrst_fresh_read: got ack=%b data=%h want 1/12", got, rd); end
    tick();
    m1_cyc = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_long_hold();
    bit got;
    logic [DW-1:0] rd;
    int bad = 0;
    m0_addr = 17'h00300; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    tick();
    m0_stb = 1'b0;
    wait_ack0(got, rd);
    m1_addr = 17'h00101; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      m1_stb = ~m1_stb;
      #1;
      if (m1_stall !== 1'b1 || m1_ack !== 1'b0 || m0_err !== 1'b0 || s_cyc !== 1'b1 || s_addr !== 17'h00300) bad++;
    end
    compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL hold_no_switch: got %0d bad cycles want 0", bad); end
    m0_cyc = 1'b0; m1_stb = 1'b1;
    tick();
    tick();
    compared++; if (m1_stall !== 1'b0 || s_addr !== 17'h00101) begin mismatched++; $display("[TB] FAIL hold_handover: got stall=%b addr=%h want 0/00101", m1_stall, s_addr); end
    tick();
    m1_stb = 1'b0;
    wait_ack1(got, rd);
    tick();
    m1_cyc = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write_read();
    test_pipelined();
    test_timeout();
    test_reset_mid_cycle();
    test_long_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] bench did not finish");
  end

endmodule
